// File: rtl/fv_obi_mem_arbiter.sv
// Two-port OBI round-robin arbiter onto one memory port, with in-order response routing.
// Optional checking (sticky protocol_err_o, SVA asserts/covers) enabled by FV_OBI_ARB_ASSERT_EN.
module fv_obi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                s_req_i,
    input  logic [2*ADDR_WIDTH-1:0]   s_addr_i,
    input  logic [1:0]                s_we_i,
    input  logic [2*DATA_WIDTH/8-1:0] s_be_i,
    input  logic [2*DATA_WIDTH-1:0]   s_wdata_i,
    output logic [1:0]                s_gnt_o,
    output logic [1:0]                s_rvalid_o,
    output logic [DATA_WIDTH-1:0]     s_rdata_o,
    output logic                      s_err_o,
    output logic                      m_req_o,
    output logic [ADDR_WIDTH-1:0]     m_addr_o,
    output logic                      m_we_o,
    output logic [DATA_WIDTH/8-1:0]   m_be_o,
    output logic [DATA_WIDTH-1:0]     m_wdata_o,
    input  logic                      m_gnt_i,
    input  logic                      m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     m_rdata_i,
    input  logic                      m_err_i,
    output logic                      protocol_err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_param
        $error("MAX_OUTSTANDING must be in 1..8");
    end

    logic [0:0]                 state_q, state_d;
    logic                       owner_q;
    logic                       rr_last_q;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;

    logic sel, sel_valid, fifo_full, fifo_empty, push, pop, head;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Selection, address-phase mux and next state
    always_comb begin
        state_d   = state_q;
        sel       = 1'b0;
        sel_valid = 1'b0;
        m_req_o   = 1'b0;
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_wdata_o = '0;
        s_gnt_o   = 2'b00;

        case (state_q)
            ST_LOCKED: begin
                sel       = owner_q;
                sel_valid = 1'b1;
            end
            default: begin
                if (!fifo_full) begin
                    case (s_req_i)
                        2'b01:   begin sel = 1'b0;       sel_valid = 1'b1; end
                        2'b10:   begin sel = 1'b1;       sel_valid = 1'b1; end
                        2'b11:   begin sel = ~rr_last_q; sel_valid = 1'b1; end
                        default: begin sel = 1'b0;       sel_valid = 1'b0; end
                    endcase
                end
            end
        endcase

        if (sel_valid) begin
            m_req_o   = s_req_i[sel];
            m_addr_o  = sel ? s_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_addr_i[ADDR_WIDTH-1:0];
            m_we_o    = s_we_i[sel];
            m_be_o    = sel ? s_be_i[2*BE_WIDTH-1:BE_WIDTH] : s_be_i[BE_WIDTH-1:0];
            m_wdata_o = sel ? s_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : s_wdata_i[DATA_WIDTH-1:0];
        end
        s_gnt_o[sel] = m_gnt_i & m_req_o;

        case (state_q)
            ST_LOCKED: if (m_gnt_i) state_d = ST_IDLE;
            default:   if (m_req_o && !m_gnt_i) state_d = ST_LOCKED;
        endcase
    end

    assign push = m_req_o & m_gnt_i;
    assign pop  = m_rvalid_i & ~fifo_empty;

    // Arbitration history and ownership FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= 1'b0;
            rr_last_q <= 1'b0;
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && m_req_o && !m_gnt_i) owner_q <= sel;
            if (push) begin
                rr_last_q        <= sel;
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Response routing back to the oldest owner
    always_comb begin
        s_rvalid_o       = 2'b00;
        s_rvalid_o[head] = pop;
    end
    assign s_rdata_o = m_rdata_i;
    assign s_err_o   = m_err_i;

`ifdef FV_OBI_ARB_ASSERT_EN
    logic [ADDR_WIDTH-1:0] lock_addr_q;
    logic                  lock_we_q;
    logic [BE_WIDTH-1:0]   lock_be_q;
    logic [DATA_WIDTH-1:0] lock_wdata_q;
    logic                  err_q;
    logic                  stray_rvalid, lock_viol, gnt_no_req;

    // Payload snapshot taken when the lock forms; it must hold until gnt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_addr_q  <= '0;
            lock_we_q    <= 1'b0;
            lock_be_q    <= '0;
            lock_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && m_req_o && !m_gnt_i) begin
                lock_addr_q  <= m_addr_o;
                lock_we_q    <= m_we_o;
                lock_be_q    <= m_be_o;
                lock_wdata_q <= m_wdata_o;
            end
            if (stray_rvalid || lock_viol || gnt_no_req) err_q <= 1'b1;
        end
    end

    assign stray_rvalid = m_rvalid_i & fifo_empty;
    assign lock_viol    = (state_q == ST_LOCKED) &&
                          (!m_req_o || m_addr_o != lock_addr_q || m_we_o != lock_we_q ||
                           m_be_o != lock_be_q || m_wdata_o != lock_wdata_q);
    assign gnt_no_req   = m_gnt_i & ~m_req_o;
    assign protocol_err_o = err_q;

    a_stray_rvalid: assert property (@(posedge clk) disable iff (!reset_n) !stray_rvalid);
    a_lock_stable:  assert property (@(posedge clk) disable iff (!reset_n) !lock_viol);
    a_gnt_no_req:   assert property (@(posedge clk) disable iff (!reset_n) !gnt_no_req);
    a_gnt_onehot:   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(s_gnt_o));
    a_rv_onehot:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(s_rvalid_o));
    a_count_max:    assert property (@(posedge clk) disable iff (!reset_n) count_q <= CNT_FULL);

    c_fifo_full:    cover property (@(posedge clk) disable iff (!reset_n) fifo_full);
    c_push_pop:     cover property (@(posedge clk) disable iff (!reset_n) push && pop);
    c_contend:      cover property (@(posedge clk) disable iff (!reset_n) s_req_i == 2'b11);
`else
    assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fv_obi_mem_arbiter.sv
// Directed self-checking bench for fv_obi_mem_arbiter (default parameters).
module tb_fv_obi_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] A_INSTR = 32'h0000_1000;
    localparam logic [AW-1:0] A_DATA  = 32'h0000_2000;
`ifdef FV_OBI_ARB_ASSERT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      s_req_i;
    logic [2*AW-1:0] s_addr_i;
    logic [1:0]      s_we_i;
    logic [7:0]      s_be_i;
    logic [2*DW-1:0] s_wdata_i;
    logic [1:0]      s_gnt_o, s_rvalid_o;
    logic [DW-1:0]   s_rdata_o;
    logic            s_err_o;
    logic            m_req_o;
    logic [AW-1:0]   m_addr_o;
    logic            m_we_o;
    logic [3:0]      m_be_o;
    logic [DW-1:0]   m_wdata_o;
    logic            m_gnt_i, m_rvalid_i, m_err_i;
    logic [DW-1:0]   m_rdata_i;
    logic            protocol_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    fv_obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_we_i(s_we_i), .s_be_i(s_be_i),
        .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o),
        .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
        .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
        .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_err_i(m_err_i), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rdata);
        s_req_i    = req;
        m_gnt_i    = gnt;
        m_rvalid_i = rv;
        m_rdata_i  = rdata;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, '0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        s_addr_i  = {A_DATA, A_INSTR};
        s_we_i    = 2'b10;
        s_be_i    = 8'h3F;
        s_wdata_i = {32'hD0D0_0002, 32'hD0D0_0001};
        m_err_i   = 1'b0;
        drive(2'b00, 1'b0, 1'b0, '0);
        check_eq("rst_m_req", 64'(m_req_o), 64'd0);
        check_eq("rst_s_gnt", 64'(s_gnt_o), 64'd0);
        check_eq("rst_s_rvalid", 64'(s_rvalid_o), 64'd0);
        check_eq("rst_perr", 64'(protocol_err_o), 64'd0);
        check_eq("rst_m_addr", 64'(m_addr_o), 64'd0);
        tick();
        reset_n = 1'b1;

        // single requester: same-cycle gnt, response next cycle
        drive(2'b01, 1'b1, 1'b0, '0);
        check_eq("single_gnt", 64'(s_gnt_o), 64'd1);
        check_eq("single_addr", 64'(m_addr_o), 64'(A_INSTR));
        check_eq("single_we", 64'(m_we_o), 64'd0);
        check_eq("single_be", 64'(m_be_o), 64'hF);
        tick();
        m_err_i = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_F00D);
        check_eq("single_rvalid", 64'(s_rvalid_o), 64'd1);
        check_eq("single_rdata", 64'(s_rdata_o), 64'hCAFE_F00D);
        check_eq("single_err", 64'(s_err_o), 64'd1);
        tick();
        m_err_i = 1'b0;

        // contention from reset: data, instr, data, instr
        do_reset();
        drive(2'b11, 1'b1, 1'b0, '0);
        check_eq("cont_gnt0", 64'(s_gnt_o), 64'd2);
        check_eq("cont_addr0", 64'(m_addr_o), 64'(A_DATA));
        check_eq("cont_wdata0", 64'(m_wdata_o), 64'hD0D0_0002);
        check_eq("cont_we0", 64'(m_we_o), 64'd1);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'h11);
        check_eq("cont_gnt1", 64'(s_gnt_o), 64'd1);
        check_eq("cont_rv1", 64'(s_rvalid_o), 64'd2);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'h22);
        check_eq("cont_gnt2", 64'(s_gnt_o), 64'd2);
        check_eq("cont_rv2", 64'(s_rvalid_o), 64'd1);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'h33);
        check_eq("cont_gnt3", 64'(s_gnt_o), 64'd1);
        check_eq("cont_rv3", 64'(s_rvalid_o), 64'd2);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h44);
        check_eq("cont_rv4", 64'(s_rvalid_o), 64'd1);
        tick();

        // lock: instr stalled, data arrives meanwhile; instr keeps the port
        drive(2'b01, 1'b0, 1'b0, '0);
        check_eq("lock_addr0", 64'(m_addr_o), 64'(A_INSTR));
        check_eq("lock_gnt0", 64'(s_gnt_o), 64'd0);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(2'b11, 1'b0, 1'b0, '0);
            check_eq($sformatf("lock_addr%0d", i), 64'(m_addr_o), 64'(A_INSTR));
            check_eq($sformatf("lock_req%0d", i), 64'(m_req_o), 64'd1);
            tick();
        end
        drive(2'b11, 1'b1, 1'b0, '0);
        check_eq("lock_gnt_instr", 64'(s_gnt_o), 64'd1);
        check_eq("lock_addr_gnt", 64'(m_addr_o), 64'(A_INSTR));
        tick();
        drive(2'b10, 1'b1, 1'b0, '0);
        check_eq("lock_gnt_data", 64'(s_gnt_o), 64'd2);
        check_eq("lock_addr_data", 64'(m_addr_o), 64'(A_DATA));
        tick();
        drive(2'b00, 1'b0, 1'b1, '0);
        check_eq("lock_rv_instr", 64'(s_rvalid_o), 64'd1);
        tick();
        drive(2'b00, 1'b0, 1'b1, '0);
        check_eq("lock_rv_data", 64'(s_rvalid_o), 64'd2);
        tick();

        // FIFO full blocks selection, even in a popping cycle
        drive(2'b01, 1'b1, 1'b0, '0);
        check_eq("full_gnt0", 64'(s_gnt_o), 64'd1);
        tick();
        drive(2'b10, 1'b1, 1'b0, '0);
        check_eq("full_gnt1", 64'(s_gnt_o), 64'd2);
        tick();
        drive(2'b01, 1'b0, 1'b0, '0);
        check_eq("full_mreq", 64'(m_req_o), 64'd0);
        check_eq("full_maddr", 64'(m_addr_o), 64'd0);
        tick();
        drive(2'b01, 1'b0, 1'b1, '0);
        check_eq("full_pop_mreq", 64'(m_req_o), 64'd0);
        check_eq("full_pop_rv", 64'(s_rvalid_o), 64'd1);
        tick();
        drive(2'b01, 1'b1, 1'b0, '0);
        check_eq("full_after_gnt", 64'(s_gnt_o), 64'd1);
        tick();
        drive(2'b00, 1'b0, 1'b1, '0);
        check_eq("full_drain_rv0", 64'(s_rvalid_o), 64'd2);
        tick();
        drive(2'b00, 1'b0, 1'b1, '0);
        check_eq("full_drain_rv1", 64'(s_rvalid_o), 64'd1);
        tick();

        // stray response with empty FIFO
        drive(2'b00, 1'b0, 1'b1, 32'h55);
        check_eq("stray_rv", 64'(s_rvalid_o), 64'd0);
        tick();
        drive(2'b00, 1'b0, 1'b0, '0);
        check_eq("stray_perr", 64'(protocol_err_o), 64'(EXP_ERR));
        tick();
        tick();
        check_eq("stray_perr_sticky", 64'(protocol_err_o), 64'(EXP_ERR));

        // reset while locked with one outstanding
        do_reset();
        drive(2'b01, 1'b1, 1'b0, '0);
        tick();
        drive(2'b10, 1'b0, 1'b0, '0);
        check_eq("mid_locking_addr", 64'(m_addr_o), 64'(A_DATA));
        tick();
        reset_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, '0);
        check_eq("mid_rst_mreq", 64'(m_req_o), 64'd0);
        check_eq("mid_rst_gnt", 64'(s_gnt_o), 64'd0);
        check_eq("mid_rst_perr", 64'(protocol_err_o), 64'd0);
        tick();
        reset_n = 1'b1;
        drive(2'b00, 1'b0, 1'b1, '0);
        check_eq("mid_stray_rv", 64'(s_rvalid_o), 64'd0);
        tick();
        drive(2'b11, 1'b1, 1'b0, '0);
        check_eq("mid_first_tie", 64'(s_gnt_o), 64'd2);
        tick();
        drive(2'b00, 1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
